// File: rtl/memarb_pkg.sv
// memarb_pkg: shared definitions for the data-memory arbiter.
//   owner_e   - requester that owns an in-flight read (OWN_CORE / OWN_HOST)
//   DEF_*     - default widths, latency and starvation limit
//   *_MIN/MAX - legal ranges for READ_LAT and MAX_WAIT
//   clamp_u   - forces a parameter into its legal range
package memarb_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_READ_LAT = 1;
  localparam int unsigned DEF_MAX_WAIT = 3;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 4;
  localparam int unsigned MAX_WAIT_MIN = 1;
  localparam int unsigned MAX_WAIT_MAX = 15;

  // Wide enough for MAX_WAIT_MAX.
  localparam int unsigned WAIT_CNT_W = 4;

  function automatic int unsigned clamp_u(input int unsigned val, input int unsigned lo,
                                          input int unsigned hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

endpackage

// File: rtl/rd_track.sv
// rd_track: READ_LAT-deep shift register of {valid, owner} for issued reads.
// Each cycle the arbiter pushes {mem_re, owner}; the tail marks the cycle in which
// mem_rdata belongs to that read.
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   in_valid, in_owner    - read issued this cycle and its requester
//   out_valid, out_owner  - read whose data is on mem_rdata this cycle
module rd_track
  import memarb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_READ_LAT
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   in_valid,
  input  owner_e in_owner,
  output logic   out_valid,
  output owner_e out_owner
);

  logic [DEPTH-1:0] valid_q;
  owner_e           owner_q [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      // Dropping every valid discards reads that were in flight at reset.
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        owner_q[i] <= OWN_CORE;
      end
    end else begin
      valid_q[0] <= in_valid;
      owner_q[0] <= in_owner;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_owner = owner_q[DEPTH-1];

endmodule

// File: rtl/memdata_arbiter.sv
// memdata_arbiter: shares one data-memory port between the core datapath and a
// host/debug loader. Grant is combinational per cycle; the core wins by default,
// the host wins once it has been refused MAX_WAIT cycles in a row (or holds the
// lock). Returned read data is steered to its owner with a one-cycle rvalid.
//
// Optional feature: define MEMARB_HOST_LOCK_EN to add the host_lock input, which
// lets the host keep the port across a burst while the core is stalled.
//
// Ports:
//   clock, reset                        - rising-edge clock, synchronous active-high reset
//   core_req/we/addr/wdata              - core request (held until granted)
//   core_gnt, core_stall                - core accepted / core must hold its PC
//   core_rdata, core_rvalid             - core read return
//   host_req/we/addr/wdata [host_lock]  - host request
//   host_gnt, host_rdata, host_rvalid   - host accept and read return
//   mem_addr/we/re/wdata, mem_rdata     - data memory port (rdata READ_LAT cycles after re)
module memdata_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned READ_LAT = DEF_READ_LAT,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,

  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
`ifdef MEMARB_HOST_LOCK_EN
  input  logic              host_lock,
`endif
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned Lat = clamp_u(READ_LAT, READ_LAT_MIN, READ_LAT_MAX);
  localparam int unsigned MaxWait = clamp_u(MAX_WAIT, MAX_WAIT_MIN, MAX_WAIT_MAX);
  localparam logic [WAIT_CNT_W-1:0] WaitMax = WAIT_CNT_W'(MaxWait);

  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic                  lock;
  logic                  host_pri;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign host_pri = (wait_cnt_q == WaitMax) | lock;

  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (!reset) begin
      // A held lock keeps the core out even when the host is idle that cycle.
      if (core_req && !lock && !(host_req && host_pri)) begin
        core_gnt = 1'b1;
      end else if (host_req) begin
        host_gnt = 1'b1;
      end
    end
  end

  assign core_stall = core_req & ~core_gnt;

  // ---------------------------------------------------------------------------
  // Memory port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (core_gnt) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_we    = core_we;
      mem_re    = ~core_we;
    end else if (host_gnt) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_we    = host_we;
      mem_re    = ~host_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Host starvation counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (host_gnt || !host_req) begin
      wait_cnt_q <= '0;
    end else if (wait_cnt_q != WaitMax) begin
      wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Host lock
  // ---------------------------------------------------------------------------
`ifdef MEMARB_HOST_LOCK_EN
  logic lock_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else if (host_gnt) begin
      // Every granted beat re-arms or releases the lock.
      lock_q <= host_lock;
    end else if (!host_req) begin
      lock_q <= 1'b0;
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read return tracking
  // ---------------------------------------------------------------------------
  logic   trk_valid;
  owner_e trk_owner;

  rd_track #(
    .DEPTH (Lat)
  ) u_rd_track (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (mem_re),
    .in_owner  (host_gnt ? OWN_HOST : OWN_CORE),
    .out_valid (trk_valid),
    .out_owner (trk_owner)
  );

  // Gating with reset also suppresses a read whose return lands in the reset cycle.
  assign core_rvalid = trk_valid & (trk_owner == OWN_CORE) & ~reset;
  assign host_rvalid = trk_valid & (trk_owner == OWN_HOST) & ~reset;

  logic [DATA_W-1:0] core_hold_q;
  logic [DATA_W-1:0] host_hold_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      core_hold_q <= '0;
      host_hold_q <= '0;
    end else begin
      if (core_rvalid) core_hold_q <= mem_rdata;
      if (host_rvalid) host_hold_q <= mem_rdata;
    end
  end

  // Fresh data is forwarded in the rvalid cycle; afterwards the hold register keeps it.
  assign core_rdata = core_rvalid ? mem_rdata : core_hold_q;
  assign host_rdata = host_rvalid ? mem_rdata : host_hold_q;

endmodule

// File: tb/tb_memdata_arbiter.sv
// tb_memdata_arbiter: self-checking bench for memdata_arbiter. Two instances share
// one stimulus stream: READ_LAT = 1 and READ_LAT = 3, both MAX_WAIT = 3. Expected
// grants are written per vector; expected read returns are pushed to a per-instance
// scoreboard queue at grant time and popped when they are due.
// Define MEMARB_HOST_LOCK_EN to also exercise the host lock burst.
module tb_memdata_arbiter;

  typedef struct {
    logic       own;  // 0 = core, 1 = host
    logic [7:0] data;
    int         due;
  } ret_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       core_req, core_we, host_req, host_we, host_lock;
  logic [7:0] core_addr, core_wdata, host_addr, host_wdata;

  logic       core_gnt [2], core_stall [2], core_rvalid [2];
  logic       host_gnt [2], host_rvalid [2], mem_we [2], mem_re [2];
  logic [7:0] core_rdata [2], host_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];

  memdata_arbiter #(
    .ADDR_W (8), .DATA_W (8), .READ_LAT (1), .MAX_WAIT (3)
  ) u_lat1 (
    .clock (clock), .reset (reset),
    .core_req (core_req), .core_we (core_we), .core_addr (core_addr),
    .core_wdata (core_wdata), .core_gnt (core_gnt[0]), .core_stall (core_stall[0]),
    .core_rdata (core_rdata[0]), .core_rvalid (core_rvalid[0]),
    .host_req (host_req), .host_we (host_we), .host_addr (host_addr),
    .host_wdata (host_wdata),
`ifdef MEMARB_HOST_LOCK_EN
    .host_lock (host_lock),
`endif
    .host_gnt (host_gnt[0]), .host_rdata (host_rdata[0]), .host_rvalid (host_rvalid[0]),
    .mem_addr (mem_addr[0]), .mem_we (mem_we[0]), .mem_re (mem_re[0]),
    .mem_wdata (mem_wdata[0]), .mem_rdata (mem_rdata[0])
  );

  memdata_arbiter #(
    .ADDR_W (8), .DATA_W (8), .READ_LAT (3), .MAX_WAIT (3)
  ) u_lat3 (
    .clock (clock), .reset (reset),
    .core_req (core_req), .core_we (core_we), .core_addr (core_addr),
    .core_wdata (core_wdata), .core_gnt (core_gnt[1]), .core_stall (core_stall[1]),
    .core_rdata (core_rdata[1]), .core_rvalid (core_rvalid[1]),
    .host_req (host_req), .host_we (host_we), .host_addr (host_addr),
    .host_wdata (host_wdata),
`ifdef MEMARB_HOST_LOCK_EN
    .host_lock (host_lock),
`endif
    .host_gnt (host_gnt[1]), .host_rdata (host_rdata[1]), .host_rvalid (host_rvalid[1]),
    .mem_addr (mem_addr[1]), .mem_we (mem_we[1]), .mem_re (mem_re[1]),
    .mem_wdata (mem_wdata[1]), .mem_rdata (mem_rdata[1])
  );

  // Memory models: synchronous read, data appears READ_LAT cycles after mem_re.
  // 0xEE marks "no read issued" so mistimed rvalids show up as bad data.
  logic [7:0] memq [2][256];
  logic [7:0] rd1;
  logic [7:0] rd3 [3];

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_we[d]) memq[d][mem_addr[d]] <= mem_wdata[d];
    end
    rd1    <= mem_re[0] ? memq[0][mem_addr[0]] : 8'hEE;
    rd3[0] <= mem_re[1] ? memq[1][mem_addr[1]] : 8'hEE;
    rd3[1] <= rd3[0];
    rd3[2] <= rd3[1];
  end

  assign mem_rdata[0] = rd1;
  assign mem_rdata[1] = rd3[2];

  // Scoreboard state.
  logic [7:0] shadow [256];
  ret_t       sbq [2][$];
  logic [7:0] hold_c [2], hold_h [2];
  int         cyc;
  int         nvec, nerr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check at negedge, update the scoreboard.
  task automatic apply(input logic rst,
                       input logic creq, input logic cwe, input logic [7:0] caddr,
                       input logic [7:0] cwd,
                       input logic hreq, input logic hwe, input logic [7:0] haddr,
                       input logic [7:0] hwd, input logic hlock,
                       input logic ecg, input logic ehg);
    logic [7:0] eaddr, ewd;
    logic       ewe, ere;
    reset      = rst;
    core_req   = creq;  core_we = cwe;  core_addr = caddr;  core_wdata = cwd;
    host_req   = hreq;  host_we = hwe;  host_addr = haddr;  host_wdata = hwd;
    host_lock  = hlock;
    ewe   = (ecg & cwe) | (ehg & hwe);
    ere   = (ecg & ~cwe) | (ehg & ~hwe);
    eaddr = ecg ? caddr : (ehg ? haddr : 8'h00);
    ewd   = ecg ? cwd : (ehg ? hwd : 8'h00);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      string p;
      logic  ev, ecv, ehv;
      ret_t  head;
      p = (d == 0) ? "lat1" : "lat3";
      check_eq({p, " core_gnt"}, 32'(core_gnt[d]), 32'(ecg));
      check_eq({p, " host_gnt"}, 32'(host_gnt[d]), 32'(ehg));
      check_eq({p, " core_stall"}, 32'(core_stall[d]), 32'(creq & ~ecg));
      check_eq({p, " mem_port"}, 32'({mem_we[d], mem_re[d], mem_addr[d], mem_wdata[d]}),
               32'({ewe, ere, eaddr, ewd}));
      ev   = 1'b0;
      head = '{own: 1'b0, data: 8'h00, due: 0};
      if (!rst && sbq[d].size() > 0 && sbq[d][0].due == cyc) begin
        ev   = 1'b1;
        head = sbq[d].pop_front();
      end
      ecv = ev & ~head.own;
      ehv = ev & head.own;
      check_eq({p, " core_rvalid"}, 32'(core_rvalid[d]), 32'(ecv));
      check_eq({p, " host_rvalid"}, 32'(host_rvalid[d]), 32'(ehv));
      if (!rst) begin
        check_eq({p, " core_rdata"}, 32'(core_rdata[d]), 32'(ecv ? head.data : hold_c[d]));
        check_eq({p, " host_rdata"}, 32'(host_rdata[d]), 32'(ehv ? head.data : hold_h[d]));
      end
      if (ecv) hold_c[d] = head.data;
      if (ehv) hold_h[d] = head.data;
      if (rst) begin
        sbq[d].delete();
        hold_c[d] = 8'h00;
        hold_h[d] = 8'h00;
      end
      if (ecg && !cwe) sbq[d].push_back('{own: 1'b0, data: shadow[caddr], due: cyc + 1 + 2 * d});
      if (ehg && !hwe) sbq[d].push_back('{own: 1'b1, data: shadow[haddr], due: cyc + 1 + 2 * d});
    end
    if (ecg && cwe) shadow[caddr] = cwd;
    if (ehg && hwe) shadow[haddr] = hwd;
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    cyc  = 0;
    for (int i = 0; i < 256; i++) begin
      shadow[i]  = 8'(i) ^ 8'h5A;
    end
    shadow[1] = 8'd10;  shadow[2] = 8'd20;  shadow[3] = 8'd30;
    shadow[7] = 8'h11;  shadow[8] = 8'h22;
    for (int i = 0; i < 256; i++) begin
      memq[0][i] = shadow[i];
      memq[1][i] = shadow[i];
    end
    for (int d = 0; d < 2; d++) begin
      hold_c[d] = 8'h00;
      hold_h[d] = 8'h00;
    end
    reset = 1'b1;
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_lock = 0;
    @(posedge clock);
    #1;

    // Reset: no grants, quiet memory port.
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Core alone: write 5 <= 0x2A, then read it back.
    apply(0, 1, 1, 8'd5, 8'h2A, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 1, 0, 8'd5, 8'h00, 0, 0, 0, 0, 0, 1, 0);
    idle(4);

    // Contention: three core grants, then the starved host, repeating.
    for (int i = 0; i < 8; i++) begin
      apply(0, 1, 0, 8'd7, 8'h00, 1, 0, 8'd8, 8'h00, 0, (i % 4) != 3, (i % 4) == 3);
    end
    idle(4);

    // Host back-to-back reads of 1, 2, 3.
    for (int k = 1; k <= 3; k++) begin
      apply(0, 0, 0, 0, 0, 1, 0, 8'(k), 8'h00, 0, 0, 1);
    end
    idle(4);

    // Write issued while a read returns, then read the written location.
    apply(0, 0, 0, 0, 0, 1, 0, 8'd1, 8'h00, 0, 0, 1);
    apply(0, 1, 1, 8'd9, 8'h55, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 1, 0, 8'd9, 8'h00, 0, 0, 0, 0, 0, 1, 0);
    idle(4);

    // Reset with reads in flight and the host partly starved: reads are dropped
    // and the starvation count restarts from zero.
    apply(0, 1, 0, 8'd5, 8'h00, 1, 0, 8'd8, 8'h00, 0, 1, 0);
    apply(0, 1, 0, 8'd5, 8'h00, 1, 0, 8'd8, 8'h00, 0, 1, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 0, 8'd7, 8'h00, 1, 0, 8'd8, 8'h00, 0, i != 3, i == 3);
    end
    idle(4);

`ifdef MEMARB_HOST_LOCK_EN
    // Host wins by starvation, then keeps the port for a locked 4-beat burst.
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 8'd9, 8'h00, 1, 1, 8'd20, 8'hA0, 1, 1, 0);
    end
    apply(0, 1, 0, 8'd9, 8'h00, 1, 1, 8'd20, 8'hA0, 1, 0, 1);
    apply(0, 1, 0, 8'd9, 8'h00, 1, 1, 8'd21, 8'hA1, 1, 0, 1);
    apply(0, 1, 0, 8'd9, 8'h00, 1, 1, 8'd22, 8'hA2, 1, 0, 1);
    apply(0, 1, 0, 8'd9, 8'h00, 1, 1, 8'd23, 8'hA3, 0, 0, 1);
    apply(0, 1, 0, 8'd9, 8'h00, 0, 0, 0, 0, 0, 1, 0);
    // Lock taken, then released by the host going idle; the core waits that cycle.
    apply(0, 0, 0, 0, 0, 1, 1, 8'd24, 8'hA4, 1, 0, 1);
    apply(0, 1, 0, 8'd20, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 1, 0, 8'd20, 8'h00, 0, 0, 0, 0, 0, 1, 0);
    idle(4);
`endif

    for (int d = 0; d < 2; d++) begin
      check_eq(d == 0 ? "lat1 drain" : "lat3 drain", 32'(sbq[d].size()), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
